// File: rtl/ex_ctrl_if.sv
// Execute-stage control bus between the core datapath and ex_ctrl_pipe.
// master: the datapath. It drives the s2 instruction context and consumes the
//         decode, forwarding, stall and flush controls.
// slave : ex_ctrl_pipe.
// Signals:
//   instr_s2, valid_s2, branch_taken, alu_result, pc_s2   datapath -> control
//   alu_sel, brun, mem_wmask, csr_we, imem_ena,
//   fwd_sel_a, fwd_sel_b, stall, flush                    control -> datapath
interface ex_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic [31:0]       instr_s2;
    logic              valid_s2;
    logic              branch_taken;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   pc_s2;
    logic [3:0]        alu_sel;
    logic              brun;
    logic [XLEN/8-1:0] mem_wmask;
    logic              csr_we;
    logic              imem_ena;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;
    logic              stall;
    logic              flush;

    modport master (
        output instr_s2, valid_s2, branch_taken, alu_result, pc_s2,
        input  alu_sel, brun, mem_wmask, csr_we, imem_ena,
               fwd_sel_a, fwd_sel_b, stall, flush
    );

    modport slave (
        input  instr_s2, valid_s2, branch_taken, alu_result, pc_s2,
        output alu_sel, brun, mem_wmask, csr_we, imem_ena,
               fwd_sel_a, fwd_sel_b, stall, flush
    );
endinterface

// File: rtl/ex_ctrl_pipe.sv
// Execute-stage control unit for the 3-stage RISC-V core.
// Decodes the s2 instruction into ALU/branch/store-mask/CSR controls and keeps
// compact s3 and writeback shadows (opcode, rd, valid). From those shadows it
// derives operand-forwarding selects, a counted load-use stall and the
// control-flow flush.
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bus    ex_ctrl_if.slave (s2 context in, control outputs out)
module ex_ctrl_pipe #(
    parameter int         XLEN         = 32,
    parameter int         STALL_CYCLES = 1,
    parameter bit         CSR_EN       = 1'b1,
    parameter logic [2:0] IMEM_WIN     = 3'b001
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_ctrl_if.slave  bus
);
    localparam int MW = XLEN / 8;
    localparam int AW = (XLEN == 64) ? 3 : 2;
    localparam logic [1:0] STALL_INIT = 2'(STALL_CYCLES - 1);

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_CSR    = 7'b1110011;

    // A bubble is NOP (addi x0,x0,0): only opcode and rd are kept in the shadows.
    localparam logic [6:0] NOP_OPC = OPC_ITYPE;

    // Instruction that writes a nonzero rd. With CSR_EN=0 a CSR op is a NOP.
    function automatic logic is_writer(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic vld);
        logic w;
        case (opc)
            OPC_RTYPE, OPC_ITYPE, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_LOAD: w = 1'b1;
            OPC_CSR:                     w = CSR_EN;
            default:                     w = 1'b0;
        endcase
        return w & vld & (rd != 5'd0);
    endfunction

    // CSRRWI carries an immediate in the rs1 field, so it is not an rs1 reader.
    function automatic logic reads_rs1(input logic [6:0] opc, input logic [2:0] f3);
        logic r;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: r = 1'b0;
            OPC_CSR:                     r = CSR_EN & (f3 != 3'b101);
            default:                     r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opc);
        logic r;
        case (opc)
            OPC_RTYPE, OPC_STORE, OPC_BRANCH: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

    // s3 beats wb; loads in s3 are excluded by the caller (data not ready yet).
    function automatic logic [1:0] pick_fwd(input logic [4:0] rs, input logic use_rs,
                                            input logic s3_fw, input logic [4:0] s3_rd,
                                            input logic s3_link, input logic wb_w,
                                            input logic [4:0] wb_rd);
        logic [1:0] sel;
        if (!use_rs) begin
            sel = 2'b00;
        end else if (s3_fw && (s3_rd == rs)) begin
            sel = s3_link ? 2'b11 : 2'b01;
        end else if (wb_w && (wb_rd == rs)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // s2 instruction fields
    logic [6:0]    opc_s;
    logic [4:0]    rd_s;
    logic [4:0]    rs1_s;
    logic [4:0]    rs2_s;
    logic [2:0]    f3_s;
    logic [AW-1:0] addr_lo_s;

    assign opc_s     = bus.instr_s2[6:0];
    assign rd_s      = bus.instr_s2[11:7];
    assign f3_s      = bus.instr_s2[14:12];
    assign rs1_s     = bus.instr_s2[19:15];
    assign rs2_s     = bus.instr_s2[24:20];
    assign addr_lo_s = bus.alu_result[AW-1:0];

    // Shadow registers and stall counter
    logic [6:0] s3_opc_q, s3_opc_d, wb_opc_q;
    logic [4:0] s3_rd_q, s3_rd_d, wb_rd_q;
    logic       s3_valid_q, s3_valid_d, wb_valid_q;
    logic [1:0] cnt_q, cnt_d;

    logic [3:0]    alu_sel_s;
    logic [MW-1:0] wmask_s;
    logic          s3_wr_s, s3_load_s, s3_link_s, wb_wr_s;
    logic          use1_s, use2_s, load_use_s, stall_s, flush_s, issue_s;
    logic          csr_we_s, imem_ena_s, brun_s;
    logic [1:0]    fwd_a_s, fwd_b_s;

    // ALU operation decode from opcode/func3 (bit30 picks sub/sra)
    always_comb begin
        alu_sel_s = 4'd0;
        if (bus.valid_s2) begin
            case (opc_s)
                OPC_RTYPE, OPC_ITYPE: begin
                    case (f3_s)
                        // addi has immediate bits at [30], so only R-type can subtract
                        3'd0:    alu_sel_s = ((opc_s == OPC_RTYPE) && bus.instr_s2[30]) ? 4'd12 : 4'd0;
                        3'd1:    alu_sel_s = 4'd1;
                        3'd2:    alu_sel_s = 4'd2;
                        3'd3:    alu_sel_s = 4'd11;
                        3'd4:    alu_sel_s = 4'd4;
                        3'd5:    alu_sel_s = bus.instr_s2[30] ? 4'd13 : 4'd5;
                        3'd6:    alu_sel_s = 4'd6;
                        3'd7:    alu_sel_s = 4'd7;
                        default: alu_sel_s = 4'd0;
                    endcase
                end
                OPC_LUI: alu_sel_s = 4'd15;
                OPC_CSR: begin
                    if (!CSR_EN) begin
                        alu_sel_s = 4'd0;
                    end else if (f3_s == 3'b001) begin
                        alu_sel_s = 4'd8;
                    end else if (f3_s == 3'b101) begin
                        alu_sel_s = 4'd15;
                    end else begin
                        alu_sel_s = 4'd0;
                    end
                end
                default: alu_sel_s = 4'd0;
            endcase
        end else begin
            alu_sel_s = 4'd0;
        end
    end

    // Store byte enables; misaligned halves/words/doublewords write nothing
    always_comb begin
        wmask_s = '0;
        if (bus.valid_s2 && (opc_s == OPC_STORE)) begin
            case (f3_s)
                3'd0:    wmask_s = MW'(1'b1) << addr_lo_s;
                3'd1:    wmask_s = addr_lo_s[0] ? '0 : (MW'(2'b11) << addr_lo_s);
                3'd2:    wmask_s = (addr_lo_s[1:0] != 2'b00) ? '0 : (MW'(4'hF) << addr_lo_s);
                3'd3:    wmask_s = ((XLEN == 64) && (addr_lo_s == '0)) ? '1 : '0;
                default: wmask_s = '0;
            endcase
        end else begin
            wmask_s = '0;
        end
    end

    assign brun_s     = bus.valid_s2 & bus.instr_s2[13];
    assign csr_we_s   = bus.valid_s2 & CSR_EN & (opc_s == OPC_CSR);
    assign imem_ena_s = bus.valid_s2 & (opc_s == OPC_STORE) &
                        (bus.alu_result[31:29] == IMEM_WIN) & bus.pc_s2[30];

    // Hazard view of the shadows
    assign s3_wr_s   = is_writer(s3_opc_q, s3_rd_q, s3_valid_q);
    assign s3_load_s = (s3_opc_q == OPC_LOAD);
    assign s3_link_s = (s3_opc_q == OPC_JAL) | (s3_opc_q == OPC_JALR);
    assign wb_wr_s   = is_writer(wb_opc_q, wb_rd_q, wb_valid_q);
    assign use1_s    = bus.valid_s2 & reads_rs1(opc_s, f3_s);
    assign use2_s    = bus.valid_s2 & reads_rs2(opc_s);

    // A new load-use stall is only recognised once the previous count has run out
    assign load_use_s = (cnt_q == 2'd0) & s3_wr_s & s3_load_s &
                        ((use1_s & (s3_rd_q == rs1_s)) | (use2_s & (s3_rd_q == rs2_s)));
    assign stall_s    = load_use_s | (cnt_q != 2'd0);
    assign flush_s    = bus.valid_s2 & ~stall_s &
                        ((opc_s == OPC_JAL) | (opc_s == OPC_JALR) |
                         ((opc_s == OPC_BRANCH) & bus.branch_taken));

    assign fwd_a_s = pick_fwd(rs1_s, use1_s, s3_wr_s & ~s3_load_s, s3_rd_q, s3_link_s, wb_wr_s, wb_rd_q);
    assign fwd_b_s = pick_fwd(rs2_s, use2_s, s3_wr_s & ~s3_load_s, s3_rd_q, s3_link_s, wb_wr_s, wb_rd_q);

    // s3 takes the s2 instruction unless it is a bubble or is being held back
    assign issue_s    = bus.valid_s2 & ~stall_s;
    assign s3_opc_d   = issue_s ? opc_s : NOP_OPC;
    assign s3_rd_d    = issue_s ? rd_s : 5'd0;
    assign s3_valid_d = issue_s;

    // Stall counter next state: load on trigger, then count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_use_s) begin
            cnt_d = STALL_INIT;
        end else if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Shadow pipeline and stall counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_opc_q   <= NOP_OPC;
            s3_rd_q    <= 5'd0;
            s3_valid_q <= 1'b0;
            wb_opc_q   <= NOP_OPC;
            wb_rd_q    <= 5'd0;
            wb_valid_q <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            s3_opc_q   <= s3_opc_d;
            s3_rd_q    <= s3_rd_d;
            s3_valid_q <= s3_valid_d;
            wb_opc_q   <= s3_opc_q;
            wb_rd_q    <= s3_rd_q;
            wb_valid_q <= s3_valid_q;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs are forced quiet while reset is held, independent of instr_s2
    assign bus.alu_sel   = rst_n ? alu_sel_s : 4'd0;
    assign bus.brun      = rst_n & brun_s;
    assign bus.mem_wmask = rst_n ? wmask_s : '0;
    assign bus.csr_we    = rst_n & csr_we_s;
    assign bus.imem_ena  = rst_n & imem_ena_s;
    assign bus.fwd_sel_a = rst_n ? fwd_a_s : 2'b00;
    assign bus.fwd_sel_b = rst_n ? fwd_b_s : 2'b00;
    assign bus.stall     = rst_n & stall_s;
    assign bus.flush     = rst_n & flush_s;
endmodule

// File: tb/tb_ex_ctrl_pipe.sv
// Bench for ex_ctrl_pipe: three instances (XLEN32/1-cycle stall,
// XLEN32/3-cycle stall, XLEN64/1-cycle stall) fed the same directed program,
// checked every cycle against an instruction-level model plus literal checks.
module tb_ex_ctrl_pipe;
    localparam logic [6:0] O_R = 7'h33, O_I = 7'h13, O_LUI = 7'h37, O_AUIPC = 7'h17;
    localparam logic [6:0] O_JAL = 7'h6F, O_JALR = 7'h67, O_LD = 7'h03, O_ST = 7'h23;
    localparam logic [6:0] O_BR = 7'h63, O_CSR = 7'h73;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ADD5   = {7'h00, 5'd2, 5'd1, 3'd0, 5'd5, 7'h33};
    localparam logic [31:0] SUB6   = {7'h20, 5'd3, 5'd5, 3'd0, 5'd6, 7'h33};
    localparam logic [31:0] LW7    = {12'h000, 5'd1, 3'd2, 5'd7, 7'h03};
    localparam logic [31:0] ADD8   = {7'h00, 5'd7, 5'd7, 3'd0, 5'd8, 7'h33};
    localparam logic [31:0] SB     = {7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h23};
    localparam logic [31:0] SH     = {7'h00, 5'd2, 5'd1, 3'd1, 5'd0, 7'h23};
    localparam logic [31:0] SW     = {7'h00, 5'd2, 5'd1, 3'd2, 5'd0, 7'h23};
    localparam logic [31:0] BEQ    = {7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63};
    localparam logic [31:0] LW1    = {12'h000, 5'd3, 3'd2, 5'd1, 7'h03};
    localparam logic [31:0] JAL1   = {20'h00000, 5'd1, 7'h6F};
    localparam logic [31:0] ADDI2  = {12'h004, 5'd1, 3'd0, 5'd2, 7'h13};
    localparam logic [31:0] ADD0   = {7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33};
    localparam logic [31:0] ADD3   = {7'h00, 5'd0, 5'd0, 3'd0, 5'd3, 7'h33};
    localparam logic [31:0] ADD9   = {7'h00, 5'd2, 5'd1, 3'd0, 5'd9, 7'h33};
    localparam logic [31:0] ADD10  = {7'h00, 5'd0, 5'd9, 3'd0, 5'd10, 7'h33};
    localparam logic [31:0] CSRRW  = {12'h300, 5'd6, 3'd1, 5'd5, 7'h73};
    localparam logic [31:0] CSRRWI = {12'h300, 5'd3, 3'd5, 5'd0, 7'h73};
    localparam logic [31:0] SRAI   = {7'h20, 5'd3, 5'd1, 3'd5, 5'd4, 7'h13};
    localparam logic [31:0] ADDIN  = {12'hFFF, 5'd1, 3'd0, 5'd4, 7'h13};
    localparam logic [31:0] LUI    = {20'h12345, 5'd6, 7'h37};
    localparam logic [31:0] SLTU   = {7'h00, 5'd2, 5'd1, 3'd3, 5'd11, 7'h33};

    typedef struct packed {
        logic [3:0] alu;
        logic       brun;
        logic [7:0] wm;
        logic       csr;
        logic       imem;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        valid, taken;
    logic [63:0] alu, pc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ex_ctrl_if #(.XLEN(32)) if0 ();
    ex_ctrl_if #(.XLEN(32)) if1 ();
    ex_ctrl_if #(.XLEN(64)) if2 ();

    assign if0.instr_s2 = instr; assign if0.valid_s2 = valid; assign if0.branch_taken = taken;
    assign if0.alu_result = alu[31:0]; assign if0.pc_s2 = pc[31:0];
    assign if1.instr_s2 = instr; assign if1.valid_s2 = valid; assign if1.branch_taken = taken;
    assign if1.alu_result = alu[31:0]; assign if1.pc_s2 = pc[31:0];
    assign if2.instr_s2 = instr; assign if2.valid_s2 = valid; assign if2.branch_taken = taken;
    assign if2.alu_result = alu; assign if2.pc_s2 = pc;

    ex_ctrl_pipe #(.XLEN(32), .STALL_CYCLES(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    ex_ctrl_pipe #(.XLEN(32), .STALL_CYCLES(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    ex_ctrl_pipe #(.XLEN(64), .STALL_CYCLES(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    exp_t act [3];
    assign act[0] = {if0.alu_sel, if0.brun, 4'b0000, if0.mem_wmask, if0.csr_we, if0.imem_ena,
                     if0.fwd_sel_a, if0.fwd_sel_b, if0.stall, if0.flush};
    assign act[1] = {if1.alu_sel, if1.brun, 4'b0000, if1.mem_wmask, if1.csr_we, if1.imem_ena,
                     if1.fwd_sel_a, if1.fwd_sel_b, if1.stall, if1.flush};
    assign act[2] = {if2.alu_sel, if2.brun, if2.mem_wmask, if2.csr_we, if2.imem_ena,
                     if2.fwd_sel_a, if2.fwd_sel_b, if2.stall, if2.flush};

    // ---------------- model: instructions in s3 / wb, remaining stall cycles
    logic [31:0] m_s3 [3];
    logic [31:0] m_wb [3];
    logic        m_s3v [3];
    logic        m_wbv [3];
    int          m_rem [3];

    function automatic int sc_of(int k);  return (k == 1) ? 3 : 1;   endfunction
    function automatic int xl_of(int k);  return (k == 2) ? 64 : 32; endfunction

    function automatic logic m_writes(logic [31:0] i, logic v);
        logic [6:0] o = i[6:0];
        return v && (i[11:7] != 5'd0) &&
               (o inside {O_R, O_I, O_LUI, O_AUIPC, O_JAL, O_JALR, O_LD, O_CSR});
    endfunction

    function automatic logic m_reads1(logic [31:0] i);
        logic [6:0] o = i[6:0];
        return !(o inside {O_LUI, O_AUIPC, O_JAL}) && !((o == O_CSR) && (i[14:12] == 3'd5));
    endfunction

    function automatic logic m_reads2(logic [31:0] i);
        return i[6:0] inside {O_R, O_ST, O_BR};
    endfunction

    function automatic logic [3:0] m_alu(logic [31:0] i);
        logic [31:0] tbl = {4'd7, 4'd6, 4'd5, 4'd4, 4'd11, 4'd2, 4'd1, 4'd0};
        logic [6:0]  o = i[6:0];
        logic [2:0]  f = i[14:12];
        logic [3:0]  r = 4'd0;
        if (o == O_R || o == O_I) begin
            r = tbl[f*4 +: 4];
            if (f == 3'd0 && o == O_R && i[30]) r = 4'd12;
            if (f == 3'd5 && i[30]) r = 4'd13;
        end else if (o == O_LUI) begin
            r = 4'd15;
        end else if (o == O_CSR) begin
            r = (f == 3'd1) ? 4'd8 : (f == 3'd5) ? 4'd15 : 4'd0;
        end
        return r;
    endfunction

    function automatic logic [7:0] m_mask(int k);
        int nb, xb, a;
        if (!valid || instr[6:0] != O_ST) return 8'h00;
        xb = xl_of(k) / 8;
        nb = 1 << instr[14:12];
        a  = int'(alu % 64'(xb));
        if (instr[14] || nb > xb || (a % nb) != 0) return 8'h00;
        return 8'(((1 << nb) - 1) << a);
    endfunction

    function automatic logic [1:0] m_fwd(int k, logic [4:0] rs, logic use_rs);
        logic [6:0] o3 = m_s3[k][6:0];
        if (!use_rs) return 2'b00;
        if (m_writes(m_s3[k], m_s3v[k]) && o3 != O_LD && m_s3[k][11:7] == rs)
            return (o3 == O_JAL || o3 == O_JALR) ? 2'b11 : 2'b01;
        if (m_writes(m_wb[k], m_wbv[k]) && m_wb[k][11:7] == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic m_trig(int k);
        logic [4:0] rd3 = m_s3[k][11:7];
        return (m_rem[k] == 0) && valid && m_writes(m_s3[k], m_s3v[k]) && (m_s3[k][6:0] == O_LD) &&
               ((m_reads1(instr) && rd3 == instr[19:15]) || (m_reads2(instr) && rd3 == instr[24:20]));
    endfunction

    function automatic logic m_stall(int k);
        return (m_rem[k] != 0) || m_trig(k);
    endfunction

    function automatic exp_t model_out(int k);
        exp_t e = '0;
        logic [6:0] o = instr[6:0];
        if (!rst_n) return e;
        if (valid) begin
            e.alu  = m_alu(instr);
            e.brun = instr[13];
            e.wm   = m_mask(k);
            e.csr  = (o == O_CSR);
            e.imem = (o == O_ST) && (alu[31:29] == 3'b001) && pc[30];
            e.fa   = m_fwd(k, instr[19:15], m_reads1(instr));
            e.fb   = m_fwd(k, instr[24:20], m_reads2(instr));
        end
        e.st = m_stall(k);
        e.fl = valid && !e.st && (o == O_JAL || o == O_JALR || (o == O_BR && taken));
        return e;
    endfunction

    // model state advance
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_s3[k] <= NOP; m_s3v[k] <= 1'b0;
                m_wb[k] <= NOP; m_wbv[k] <= 1'b0;
                m_rem[k] <= 0;
            end else begin
                m_wb[k]  <= m_s3[k];
                m_wbv[k] <= m_s3v[k];
                m_s3[k]  <= (m_stall(k) || !valid) ? NOP : instr;
                m_s3v[k] <= !(m_stall(k) || !valid);
                m_rem[k] <= (m_rem[k] != 0) ? m_rem[k] - 1 : (m_trig(k) ? sc_of(k) - 1 : 0);
            end
        end
    end

    // per-cycle comparison of all three instances against the model
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act[k] !== model_out(k)) begin
                errors++;
                $display("FAIL model inst%0d t=%0t: got %h expected %h", k, $time, act[k], model_out(k));
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // one s2 cycle: drive after the rising edge, return at the falling edge
    task automatic issue(input logic [31:0] ins, input logic v = 1'b1, input logic tk = 1'b0,
                         input logic [63:0] a = 64'd0, input logic [63:0] p = 64'd0);
        @(posedge clk);
        #1;
        instr = ins; valid = v; taken = tk; alu = a; pc = p;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; instr = JAL1; valid = 1'b1; taken = 1'b0; alu = 64'd0; pc = 64'd0;
        @(negedge clk);
        chk("reset_alu", {28'd0, if0.alu_sel}, 32'd0);
        chk("reset_flush", {31'd0, if0.flush}, 32'd0);
        chk("reset_stall", {31'd0, if0.stall}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; valid = 1'b0; instr = NOP;

        // ALU result forwarding from s3
        issue(ADD5);
        issue(SUB6);
        chk("sub_fwd_a", {30'd0, if0.fwd_sel_a}, 32'd1);
        chk("sub_alu", {28'd0, if0.alu_sel}, 32'd12);
        chk("sub_stall", {31'd0, if0.stall}, 32'd0);
        issue(NOP, 1'b0);

        // load-use: 1-cycle and 3-cycle stall
        issue(LW7);
        issue(ADD8);
        chk("lu_stall_1c", {31'd0, if0.stall}, 32'd1);
        chk("lu_stall_3c_c1", {31'd0, if1.stall}, 32'd1);
        issue(ADD8);
        chk("lu_resume_stall", {31'd0, if0.stall}, 32'd0);
        chk("lu_resume_fwd_a", {30'd0, if0.fwd_sel_a}, 32'd2);
        chk("lu_resume_fwd_b", {30'd0, if0.fwd_sel_b}, 32'd2);
        chk("lu_stall_3c_c2", {31'd0, if1.stall}, 32'd1);
        issue(ADD8);
        chk("lu_stall_3c_c3", {31'd0, if1.stall}, 32'd1);
        issue(ADD8);
        chk("lu_stall_3c_end", {31'd0, if1.stall}, 32'd0);
        issue(NOP, 1'b0);
        issue(NOP, 1'b0);

        // reset pulse in the middle of a 3-cycle stall
        issue(LW7);
        issue(ADD8);
        issue(ADD8);
        chk("rst_pre_stall", {31'd0, if1.stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_stall_now", {31'd0, if1.stall}, 32'd0);
        chk("rst_fwd_now", {30'd0, if0.fwd_sel_a}, 32'd0);
        chk("rst_alu_now", {28'd0, if1.alu_sel}, 32'd0);
        #1 rst_n = 1'b1;
        issue(ADD8);
        chk("rst_after_stall", {31'd0, if1.stall}, 32'd0);
        chk("rst_after_fwd_a", {30'd0, if1.fwd_sel_a}, 32'd0);
        issue(NOP, 1'b0);
        issue(NOP, 1'b0);

        // store byte masks and IMEM window
        issue(SH, 1'b1, 1'b0, 64'h0000_0000_0000_1002);
        chk("sh_mask", {28'd0, if0.mem_wmask}, 32'hC);
        issue(SW, 1'b1, 1'b0, 64'h0000_0000_0000_1001);
        chk("sw_misaligned", {28'd0, if0.mem_wmask}, 32'h0);
        issue(SB, 1'b1, 1'b0, 64'h0000_0000_0000_1007);
        chk("sb_mask64", {24'd0, if2.mem_wmask}, 32'h80);
        chk("sb_mask32", {28'd0, if0.mem_wmask}, 32'h8);
        issue(SW, 1'b1, 1'b0, 64'h0000_0000_2000_0004);
        chk("sw_mask64_hi", {24'd0, if2.mem_wmask}, 32'hF0);
        issue(SW, 1'b1, 1'b0, 64'h0000_0000_2000_0000, 64'h0000_0000_4000_0000);
        chk("imem_ena", {31'd0, if0.imem_ena}, 32'd1);

        // branch flush, plain and behind a load-use stall
        issue(BEQ, 1'b1, 1'b1);
        chk("beq_flush", {31'd0, if0.flush}, 32'd1);
        issue(NOP, 1'b0);
        chk("beq_flush_once", {31'd0, if0.flush}, 32'd0);
        issue(LW1);
        issue(BEQ, 1'b1, 1'b1);
        chk("beq_hz_stall", {31'd0, if0.stall}, 32'd1);
        chk("beq_hz_noflush", {31'd0, if0.flush}, 32'd0);
        issue(BEQ, 1'b1, 1'b1);
        chk("beq_hz_flush", {31'd0, if0.flush}, 32'd1);
        chk("beq_hz_fwd_a", {30'd0, if0.fwd_sel_a}, 32'd2);
        issue(NOP, 1'b0);
        issue(NOP, 1'b0);

        // link forwarding, x0 never forwards, wb forwarding
        issue(JAL1);
        chk("jal_flush", {31'd0, if0.flush}, 32'd1);
        issue(ADDI2);
        chk("jal_link_fwd", {30'd0, if0.fwd_sel_a}, 32'd3);
        issue(ADD0);
        issue(ADD3);
        chk("x0_fwd_a", {30'd0, if0.fwd_sel_a}, 32'd0);
        chk("x0_fwd_b", {30'd0, if0.fwd_sel_b}, 32'd0);
        issue(ADD9);
        issue(NOP, 1'b0);
        issue(ADD10);
        chk("wb_fwd_a", {30'd0, if0.fwd_sel_a}, 32'd2);

        // remaining decode cases
        issue(CSRRW);
        chk("csrrw_alu", {28'd0, if0.alu_sel}, 32'd8);
        chk("csrrw_we", {31'd0, if0.csr_we}, 32'd1);
        issue(CSRRWI);
        chk("csrrwi_alu", {28'd0, if0.alu_sel}, 32'd15);
        issue(SRAI);
        chk("srai_alu", {28'd0, if0.alu_sel}, 32'd13);
        issue(ADDIN);
        chk("addi_neg_alu", {28'd0, if0.alu_sel}, 32'd0);
        issue(LUI);
        chk("lui_alu", {28'd0, if0.alu_sel}, 32'd15);
        issue(SLTU);
        chk("sltu_alu", {28'd0, if0.alu_sel}, 32'd11);
        issue(SLTU, 1'b0);
        chk("bubble_alu", {28'd0, if0.alu_sel}, 32'd0);
        issue(NOP, 1'b0);
        issue(NOP, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_ctrl_pipe.md
Name: ex_ctrl_pipe

Overview:
- Parametrised execute-stage control unit for the 3-stage RISC-V core.
- Decodes the s2 instruction into ALU, branch, store-mask and CSR controls, and keeps its own s3/writeback instruction shadow registers.
- From those registers it drives operand-forwarding selects, a counted load-use stall and a control-flow flush.
- Replaces the purely combinational s2 decode path; the datapath consumes its outputs directly.

Parameters:
- XLEN, 32, datapath width; store byte mask is XLEN/8 bits (32 or 64 only).
- STALL_CYCLES, 1, load-use stall length in cycles (1..3).
- CSR_EN, 1, 0 forces csr_we low and decodes OPC_CSR as NOP.
- IMEM_WIN, 3'b001, alu_result[31:29] window that enables IMEM writes.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_s2  in  32  instruction in s2.
- valid_s2  in  1  instr_s2 is live (0 = bubble).
- branch_taken  in  1  s2 branch comparator result.
- alu_result  in  XLEN  s2 ALU output (store address).
- pc_s2  in  XLEN  PC of instr_s2.
- alu_sel  out  4  ALU op (0 add, 1 sll, 2 slt, 4 xor, 5 srl, 6 or, 7 and, 8 passA, 11 sltu, 12 sub, 13 sra, 15 passB).
- brun  out  1  unsigned branch compare (instr_s2[13]).
- mem_wmask  out  XLEN/8  store byte enables.
- csr_we  out  1  CSR write.
- imem_ena  out  1  IMEM write enable.
- fwd_sel_a  out  2  rs1 source select.
- fwd_sel_b  out  2  rs2 source select.
  - Encoding for both: 00 regfile, 01 s3 ALU result, 10 wb data, 11 s3 pc+4.
- stall  out  1  hold PC/s1/s2; insert bubble into s3.
- flush  out  1  kill the s1 instruction.

Behaviour:
- Decode (combinational on instr_s2, gated by valid_s2):
  - alu_sel follows the opcode/func3 map above.
  - func7 bit30 selects sub or sra; LUI and CSRRWI map to 15, CSRRW to 8, all other opcodes to 0.
  - Any decode with valid_s2=0 outputs zero.
- mem_wmask (STORE only, else 0), with a = alu_result[log2(XLEN/8)-1:0]:
  - sb: 1<<a.
  - sh: 2'b11<<a.
  - sw: 4'hF<<a.
  - sd (XLEN=64 only): all ones.
  - Misaligned sh/sw/sd: mask 0.
- imem_ena = STORE & alu_result[31:29]==IMEM_WIN & pc_s2[30].
- csr_we = valid CSR opcode & CSR_EN.
- Pipeline shadow registers:
  - On each clk, s3 <= (stall|~valid_s2) ? bubble : instr_s2, and wb <= s3.
  - A bubble is NOP 0x00000013 with valid=0.
  - Reset loads bubbles into both.
- Writers: RTYPE, ITYPE, LUI, AUIPC, JAL, JALR, LOAD, CSR, with valid=1 and rd!=0.
- Readers:
  - rs1: everything except LUI, AUIPC, JAL, CSRRWI.
  - rs2: RTYPE, STORE, BRANCH.
- Forwarding per operand:
  - s3 match takes priority over wb match.
  - s3 match: 11 if s3 is JAL/JALR, 01 otherwise.
  - A LOAD in s3 never forwards from s3.
  - wb match: 10.
  - No match: 00.
- Load-use stall:
  - Trigger: LOAD in s3 whose rd matches a read rs of a valid s2 instruction, and counter==0.
  - On trigger, the counter loads STALL_CYCLES-1 and stall=1 that cycle.
  - While counter!=0, stall=1 and the counter decrements.
  - The consumer resumes once the load reaches wb (sel 10) or the regfile.
- Flush:
  - flush = valid_s2 & ~stall & (JAL | JALR | (BRANCH & branch_taken)).
  - Asserted for exactly 1 cycle per control transfer; stall always suppresses flush.
- Reset:
  - Async reset clears the counter mid-stall.
  - stall=0, flush=0, fwd selects=00, all decode outputs 0 while rst_n=0.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 → when sub is in s2: fwd_sel_a=01, alu_sel=12, stall=0.
- lw x7,0(x1) then add x8,x7,x7, STALL_CYCLES=1 → stall=1 for exactly 1 cycle, s3 gets bubble, next cycle fwd_sel_a=fwd_sel_b=10.
- STALL_CYCLES=3, same pair → stall high 3 cycles; rst_n pulsed low in cycle 2 → stall=0 immediately, s3/wb bubbles.
- sh at alu_result=0x...2 → mem_wmask=4'b1100; sw at 0x...1 → 0; XLEN=64 sb at 0x...7 → 8'h80.
- beq taken with valid_s2=1, no hazard → flush=1 for 1 cycle; same beq with rs1 hazard on an s3 load → stall=1, flush=0, then flush=1 the cycle after.
- jal x1 in s3, addi x2,x1,4 in s2 → fwd_sel_a=11; writes to x0 never forward (fwd_sel=00).
